tag_ram_ctrl: RTL and testbench
===============================

TAG_RAM_CTRL -- requirements
Module: tag_ram_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 256, number of tag entries (power of two).
REQ-002 SHALL have parameter WIDTH, default 22, tag entry width in bits.
REQ-003 SHALL have parameter INIT_VALUE, default 0, entry value written by the clear sweep.
REQ-004 SHALL have port clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-006 SHALL have port flush_i  in  1  request to re-run the clear sweep.
REQ-007 SHALL have port init_done_o  out  1  high when the clear sweep is finished and requests are accepted.
REQ-008 SHALL have port rd_valid_i  in  1  lookup request.
REQ-009 SHALL have port rd_addr_i  in  log2(DEPTH)  lookup index.
REQ-010 SHALL have port rd_ready_o  out  1  lookup grant this cycle.
REQ-011 SHALL have port rd_data_o  out  WIDTH  lookup result.
REQ-012 SHALL have port rd_data_valid_o  out  1  qualifies rd_data_o.
REQ-013 SHALL have port wr_valid_i  in  1  update request.
REQ-014 SHALL have port wr_addr_i  in  log2(DEPTH)  update index.
REQ-015 SHALL have port wr_data_i  in  WIDTH  update value.
REQ-016 SHALL have port wr_ready_o  out  1  update grant this cycle.
REQ-017 SHALL have ports ram_cen_o, ram_wen_o, ram_a_o, ram_d_o  out  1/1/log2(DEPTH)/WIDTH  single-port RAM enable, write, address, data (active-high).
REQ-018 SHALL have port ram_q_i  in  WIDTH  RAM read data, valid one cycle after a read.

Function
REQ-019 SHALL implement FSM states INIT and RUN; rst forces INIT with sweep counter 0.
REQ-020 In INIT SHALL assert ram_cen_o=1, ram_wen_o=1, ram_a_o=counter, ram_d_o=INIT_VALUE each cycle, incrementing counter.
REQ-021 SHALL go INIT->RUN the cycle after writing entry DEPTH-1; counter wraps to 0.
REQ-022 In INIT SHALL hold rd_ready_o=0, wr_ready_o=0, init_done_o=0.
REQ-023 In RUN SHALL hold init_done_o=1 and issue at most one RAM access per cycle.
REQ-024 Grant rule: a request is granted when valid and (only requester, or round-robin pointer selects it); ready is combinational from valid, state and pointer.
REQ-025 When both rd_valid_i and wr_valid_i are high, SHALL grant the side not granted in the last contended cycle; pointer resets to favour write.
REQ-026 A write grant SHALL drive ram_cen_o=1, ram_wen_o=1, ram_a_o=wr_addr_i, ram_d_o=wr_data_i.
REQ-027 A read grant SHALL drive ram_cen_o=1, ram_wen_o=0, ram_a_o=rd_addr_i; rd_data_valid_o=1 exactly one cycle later with rd_data_o=ram_q_i.
REQ-028 With no grant SHALL drive ram_cen_o=0, ram_wen_o=0.
REQ-029 A read granted the cycle after a write to the same index SHALL return the written value.
REQ-030 flush_i high in RUN SHALL move to INIT next cycle; grants in the flush_i cycle still complete; a read granted then still returns rd_data_valid_o.
REQ-031 flush_i in INIT SHALL be ignored; sweep is not restarted.
REQ-032 Ungranted requesters SHALL hold valid/addr/data stable until granted.

Reset
REQ-033 On rst: state=INIT, counter=0, pointer=write, rd_data_valid_o=0, init_done_o=0, rd_ready_o=0, wr_ready_o=0, ram_cen_o=0.
REQ-034 rst asserted mid-sweep or mid-read SHALL abandon the operation; the sweep restarts from index 0 after release.

Configuration
REQ-035 Macro TAG_RAM_CTRL_INIT_EN defined: INIT sweep and flush_i behave as above.
REQ-036 Macro undefined: reset enters RUN directly, init_done_o=1 from the first cycle after reset, flush_i ignored, RAM contents undefined.

Structure
REQ-037 Shared package SHALL hold the tag-RAM depth/width constants and the FSM state enum.
REQ-038 Round-robin two-way arbiter SHALL be sub-module tag_ram_arb2.

Verification
REQ-039 Reset release -> 256 consecutive writes, addr 0..255, data 0; init_done_o rises cycle 257; a read of addr 0x80 returns 0.
REQ-040 Write addr 0x12 data 0x2ABCD, next cycle read 0x12 -> rd_data_valid_o one cycle later, rd_data_o=0x2ABCD.
REQ-041 rd_valid_i and wr_valid_i both held high for 4 cycles -> grants alternate W,R,W,R.
REQ-042 flush_i pulse with read granted same cycle -> read data returned, then full 256-cycle sweep, readys low throughout.
REQ-043 rst asserted at sweep counter 100 -> after release, sweep restarts at addr 0, finishes after 256 writes.

Source files
------------

// File: rtl/tag_ram_ctrl_pkg.sv
// Shared constants and FSM encoding for the tag-RAM controller.
package tag_ram_ctrl_pkg;

    localparam int unsigned TAG_DEPTH = 256;
    localparam int unsigned TAG_WIDTH = 22;
    localparam int unsigned TAG_AW    = $clog2(TAG_DEPTH);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/tag_ram_arb2.sv
// Two-way round-robin arbiter between a write and a read requester.
// The pointer only moves on contended cycles, so an uncontended grant
// never steals the turn of the other side. Reset favours the write side.
module tag_ram_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic req_wr_i,
    input  logic req_rd_i,
    output logic gnt_wr_o,
    output logic gnt_rd_o
);

    logic prio_rd_q;
    logic prio_rd_d;

    // Grant decision and pointer update for the next contended cycle.
    always_comb begin
        gnt_wr_o  = 1'b0;
        gnt_rd_o  = 1'b0;
        prio_rd_d = prio_rd_q;
        if (!en_i) begin
            gnt_wr_o = 1'b0;
            gnt_rd_o = 1'b0;
        end else if (req_wr_i && req_rd_i) begin
            if (prio_rd_q) begin
                gnt_rd_o = 1'b1;
            end else begin
                gnt_wr_o = 1'b1;
            end
            prio_rd_d = !prio_rd_q;
        end else begin
            gnt_wr_o = req_wr_i;
            gnt_rd_o = req_rd_i;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_rd_q <= 1'b0;
        end else begin
            prio_rd_q <= prio_rd_d;
        end
    end

endmodule

// File: rtl/tag_ram_ctrl.sv
// Tag-RAM controller: clears a single-port RAM after reset/flush, then
// arbitrates one read or write access per cycle onto the RAM port.
// Optional feature macro: TAG_RAM_CTRL_INIT_EN (clear sweep and flush_i).
// Without it the block comes out of reset straight into RUN.
module tag_ram_ctrl
    import tag_ram_ctrl_pkg::*;
#(
    parameter int unsigned      DEPTH      = TAG_DEPTH,
    parameter int unsigned      WIDTH      = TAG_WIDTH,
    parameter logic [WIDTH-1:0] INIT_VALUE = {WIDTH{1'b0}}
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    output logic                     init_done_o,
    input  logic                     rd_valid_i,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
    output logic                     rd_ready_o,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     rd_data_valid_o,
    input  logic                     wr_valid_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    output logic                     wr_ready_o,
    output logic                     ram_cen_o,
    output logic                     ram_wen_o,
    output logic [$clog2(DEPTH)-1:0] ram_a_o,
    output logic [WIDTH-1:0]         ram_d_o,
    input  logic [WIDTH-1:0]         ram_q_i
);

    localparam int unsigned   AW       = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
`ifdef TAG_RAM_CTRL_INIT_EN
    localparam state_e        RST_STATE = ST_INIT;
`else
    localparam state_e        RST_STATE = ST_RUN;
`endif

    state_e state_q;
    state_e state_d;
    logic   rd_data_valid_q;
    logic   rd_data_valid_d;
    logic   active_s;
    logic   rd_gnt_s;
    logic   wr_gnt_s;

`ifdef TAG_RAM_CTRL_INIT_EN
    logic [AW-1:0] cnt_q;
    logic [AW-1:0] cnt_d;
`else
    logic unused_flush_s;
    assign unused_flush_s = flush_i;
`endif

    // Requests are only served in RUN and never while reset is held.
    assign active_s        = (state_q == ST_RUN) && !rst;
    assign init_done_o     = active_s;
    assign rd_ready_o      = rd_gnt_s;
    assign wr_ready_o      = wr_gnt_s;
    assign rd_data_o       = ram_q_i;
    assign rd_data_valid_o = rd_data_valid_q;

    tag_ram_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .en_i     (active_s),
        .req_wr_i (wr_valid_i),
        .req_rd_i (rd_valid_i),
        .gnt_wr_o (wr_gnt_s),
        .gnt_rd_o (rd_gnt_s)
    );

    // Next-state, sweep counter and RAM port drive.
    always_comb begin
        state_d         = state_q;
        rd_data_valid_d = rd_gnt_s;
        ram_cen_o       = 1'b0;
        ram_wen_o       = 1'b0;
        ram_a_o         = {AW{1'b0}};
        ram_d_o         = INIT_VALUE;
`ifdef TAG_RAM_CTRL_INIT_EN
        cnt_d           = cnt_q;
`endif
        case (state_q)
            ST_INIT: begin
`ifdef TAG_RAM_CTRL_INIT_EN
                if (!rst) begin
                    ram_cen_o = 1'b1;
                    ram_wen_o = 1'b1;
                    ram_a_o   = cnt_q;
                    ram_d_o   = INIT_VALUE;
                    cnt_d     = cnt_q + AW'(1'b1);
                    if (cnt_q == LAST_IDX) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_INIT;
                    end
                end else begin
                    state_d = ST_INIT;
                end
`else
                state_d = ST_RUN;
`endif
            end
            ST_RUN: begin
                if (wr_gnt_s) begin
                    ram_cen_o = 1'b1;
                    ram_wen_o = 1'b1;
                    ram_a_o   = wr_addr_i;
                    ram_d_o   = wr_data_i;
                end else if (rd_gnt_s) begin
                    ram_cen_o = 1'b1;
                    ram_wen_o = 1'b0;
                    ram_a_o   = rd_addr_i;
                end else begin
                    ram_cen_o = 1'b0;
                    ram_wen_o = 1'b0;
                end
`ifdef TAG_RAM_CTRL_INIT_EN
                // A grant in the flush cycle still completes; the sweep
                // starts on the following cycle from index 0.
                if (flush_i && !rst) begin
                    state_d = ST_INIT;
                    cnt_d   = {AW{1'b0}};
                end else begin
                    state_d = ST_RUN;
                end
`else
                state_d = ST_RUN;
`endif
            end
            default: begin
                state_d = RST_STATE;
            end
        endcase
    end

    // FSM state and read-data qualifier registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= RST_STATE;
            rd_data_valid_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            rd_data_valid_q <= rd_data_valid_d;
        end
    end

`ifdef TAG_RAM_CTRL_INIT_EN
    // Clear-sweep index register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= {AW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_tag_ram_ctrl.sv
// Directed, table-driven bench for tag_ram_ctrl with a behavioural
// single-port RAM (read data one cycle after the read).
module tb_tag_ram_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush_i = 1'b0;
    logic        init_done_o;
    logic        rd_valid_i = 1'b0;
    logic [7:0]  rd_addr_i = 8'h00;
    logic        rd_ready_o;
    logic [21:0] rd_data_o;
    logic        rd_data_valid_o;
    logic        wr_valid_i = 1'b0;
    logic [7:0]  wr_addr_i = 8'h00;
    logic [21:0] wr_data_i = 22'h0;
    logic        wr_ready_o;
    logic        ram_cen_o;
    logic        ram_wen_o;
    logic [7:0]  ram_a_o;
    logic [21:0] ram_d_o;
    logic [21:0] ram_q;

    always #5 clk = ~clk;

    tag_ram_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .flush_i         (flush_i),
        .init_done_o     (init_done_o),
        .rd_valid_i      (rd_valid_i),
        .rd_addr_i       (rd_addr_i),
        .rd_ready_o      (rd_ready_o),
        .rd_data_o       (rd_data_o),
        .rd_data_valid_o (rd_data_valid_o),
        .wr_valid_i      (wr_valid_i),
        .wr_addr_i       (wr_addr_i),
        .wr_data_i       (wr_data_i),
        .wr_ready_o      (wr_ready_o),
        .ram_cen_o       (ram_cen_o),
        .ram_wen_o       (ram_wen_o),
        .ram_a_o         (ram_a_o),
        .ram_d_o         (ram_d_o),
        .ram_q_i         (ram_q)
    );

    // RAM model, pre-filled with a non-zero pattern so the clear sweep is visible.
    logic [21:0] mem [256];
    bit          mem_filled = 1'b0;
    always @(posedge clk) begin
        if (!mem_filled) begin
            for (int i = 0; i < 256; i++) mem[i] <= 22'h155555;
            mem_filled <= 1'b1;
        end else if (ram_cen_o) begin
            if (ram_wen_o) mem[ram_a_o] <= ram_d_o;
            else           ram_q <= mem[ram_a_o];
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Checks n sweep cycles starting at index 0; flush_i pulsed at flush_at.
    task automatic run_sweep(input int n, input int flush_at, input string tag);
        for (int k = 0; k < n; k++) begin
            flush_i = (k == flush_at);
            #1;
            chk($sformatf("%s_cen_%0d", tag, k), 32'(ram_cen_o), 32'd1);
            chk($sformatf("%s_wen_%0d", tag, k), 32'(ram_wen_o), 32'd1);
            chk($sformatf("%s_addr_%0d", tag, k), 32'(ram_a_o), 32'(k));
            chk($sformatf("%s_data_%0d", tag, k), 32'(ram_d_o), 32'd0);
            chk($sformatf("%s_done_%0d", tag, k), 32'(init_done_o), 32'd0);
            chk($sformatf("%s_rrdy_%0d", tag, k), 32'(rd_ready_o), 32'd0);
            chk($sformatf("%s_wrdy_%0d", tag, k), 32'(wr_ready_o), 32'd0);
            tick();
        end
        flush_i = 1'b0;
    endtask

    typedef struct {
        logic        rv;
        logic [7:0]  ra;
        logic        wv;
        logic [7:0]  wa;
        logic [21:0] wd;
        logic        e_rr;
        logic        e_wr;
        logic        e_cen;
        logic        e_wen;
        logic [7:0]  e_a;
        logic [21:0] e_d;
        logic        e_rdv;
        logic [21:0] e_rdd;
    } vec_t;

    vec_t vecs [18];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // rd, ra, wr, wa, wd | rrdy, wrdy, cen, wen, a, d, rdv, rdata
        vecs[0]  = '{1'b0, 8'h00, 1'b1, 8'h12, 22'h2ABCD,  1'b0, 1'b1, 1'b1, 1'b1, 8'h12, 22'h2ABCD,  1'b0, 22'h0};
        vecs[1]  = '{1'b1, 8'h12, 1'b0, 8'h00, 22'h0,      1'b1, 1'b0, 1'b1, 1'b0, 8'h12, 22'h0,      1'b0, 22'h0};
        vecs[2]  = '{1'b0, 8'h00, 1'b0, 8'h00, 22'h0,      1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 22'h0,      1'b1, 22'h2ABCD};
        vecs[3]  = '{1'b0, 8'h00, 1'b1, 8'h34, 22'h1,      1'b0, 1'b1, 1'b1, 1'b1, 8'h34, 22'h1,      1'b0, 22'h0};
        vecs[4]  = '{1'b0, 8'h00, 1'b1, 8'h3F, 22'h3FFFFF, 1'b0, 1'b1, 1'b1, 1'b1, 8'h3F, 22'h3FFFFF, 1'b0, 22'h0};
        vecs[5]  = '{1'b1, 8'h3F, 1'b0, 8'h00, 22'h0,      1'b1, 1'b0, 1'b1, 1'b0, 8'h3F, 22'h0,      1'b0, 22'h0};
        vecs[6]  = '{1'b1, 8'h34, 1'b0, 8'h00, 22'h0,      1'b1, 1'b0, 1'b1, 1'b0, 8'h34, 22'h0,      1'b1, 22'h3FFFFF};
        vecs[7]  = '{1'b0, 8'h00, 1'b0, 8'h00, 22'h0,      1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 22'h0,      1'b1, 22'h1};
        vecs[8]  = '{1'b1, 8'h12, 1'b1, 8'h50, 22'h0ABCD,  1'b0, 1'b1, 1'b1, 1'b1, 8'h50, 22'h0ABCD,  1'b0, 22'h0};
        vecs[9]  = '{1'b1, 8'h12, 1'b1, 8'h51, 22'h11111,  1'b1, 1'b0, 1'b1, 1'b0, 8'h12, 22'h0,      1'b0, 22'h0};
        vecs[10] = '{1'b1, 8'h50, 1'b1, 8'h51, 22'h11111,  1'b0, 1'b1, 1'b1, 1'b1, 8'h51, 22'h11111,  1'b1, 22'h2ABCD};
        vecs[11] = '{1'b1, 8'h50, 1'b1, 8'h52, 22'h22222,  1'b1, 1'b0, 1'b1, 1'b0, 8'h50, 22'h0,      1'b0, 22'h0};
        vecs[12] = '{1'b0, 8'h00, 1'b1, 8'h52, 22'h22222,  1'b0, 1'b1, 1'b1, 1'b1, 8'h52, 22'h22222,  1'b1, 22'h0ABCD};
        vecs[13] = '{1'b1, 8'h51, 1'b1, 8'h60, 22'h5,      1'b0, 1'b1, 1'b1, 1'b1, 8'h60, 22'h5,      1'b0, 22'h0};
        vecs[14] = '{1'b1, 8'h51, 1'b0, 8'h00, 22'h0,      1'b1, 1'b0, 1'b1, 1'b0, 8'h51, 22'h0,      1'b0, 22'h0};
        vecs[15] = '{1'b1, 8'h52, 1'b0, 8'h00, 22'h0,      1'b1, 1'b0, 1'b1, 1'b0, 8'h52, 22'h0,      1'b1, 22'h11111};
        vecs[16] = '{1'b0, 8'h00, 1'b0, 8'h00, 22'h0,      1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 22'h0,      1'b1, 22'h22222};
        vecs[17] = '{1'b0, 8'h00, 1'b0, 8'h00, 22'h0,      1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 22'h0,      1'b0, 22'h0};

        // Reset state, with both requesters asserted to show they are held off.
        rd_valid_i = 1'b1;
        wr_valid_i = 1'b1;
        wr_addr_i  = 8'h12;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_init_done", 32'(init_done_o), 32'd0);
        chk("rst_rd_ready", 32'(rd_ready_o), 32'd0);
        chk("rst_wr_ready", 32'(wr_ready_o), 32'd0);
        chk("rst_ram_cen", 32'(ram_cen_o), 32'd0);
        chk("rst_rd_data_valid", 32'(rd_data_valid_o), 32'd0);
        rd_valid_i = 1'b0;
        wr_valid_i = 1'b0;
        wr_addr_i  = 8'h00;
        rst = 1'b0;

`ifdef TAG_RAM_CTRL_INIT_EN
        run_sweep(256, -1, "sweep0");
        rd_valid_i = 1'b1;
        rd_addr_i  = 8'h80;
        #1;
        chk("sweep0_init_done", 32'(init_done_o), 32'd1);
        chk("rd80_ready", 32'(rd_ready_o), 32'd1);
        tick();
        rd_valid_i = 1'b0;
        #1;
        chk("rd80_valid", 32'(rd_data_valid_o), 32'd1);
        chk("rd80_data", 32'(rd_data_o), 32'd0);
        tick();
`else
        #1;
        chk("boot_init_done", 32'(init_done_o), 32'd1);
        tick();
`endif

        // Table-driven single-cycle vectors.
        for (int i = 0; i < 18; i++) begin
            rd_valid_i = vecs[i].rv;
            rd_addr_i  = vecs[i].ra;
            wr_valid_i = vecs[i].wv;
            wr_addr_i  = vecs[i].wa;
            wr_data_i  = vecs[i].wd;
            #1;
            chk($sformatf("v%0d_rd_ready", i), 32'(rd_ready_o), 32'(vecs[i].e_rr));
            chk($sformatf("v%0d_wr_ready", i), 32'(wr_ready_o), 32'(vecs[i].e_wr));
            chk($sformatf("v%0d_ram_cen", i), 32'(ram_cen_o), 32'(vecs[i].e_cen));
            chk($sformatf("v%0d_ram_wen", i), 32'(ram_wen_o), 32'(vecs[i].e_wen));
            if (vecs[i].e_cen) chk($sformatf("v%0d_ram_a", i), 32'(ram_a_o), 32'(vecs[i].e_a));
            if (vecs[i].e_wen) chk($sformatf("v%0d_ram_d", i), 32'(ram_d_o), 32'(vecs[i].e_d));
            chk($sformatf("v%0d_rd_data_valid", i), 32'(rd_data_valid_o), 32'(vecs[i].e_rdv));
            if (vecs[i].e_rdv) chk($sformatf("v%0d_rd_data", i), 32'(rd_data_o), 32'(vecs[i].e_rdd));
            chk($sformatf("v%0d_init_done", i), 32'(init_done_o), 32'd1);
            tick();
        end
        rd_valid_i = 1'b0;
        wr_valid_i = 1'b0;

`ifdef TAG_RAM_CTRL_INIT_EN
        // Flush with a read granted in the same cycle, then a full sweep.
        rd_valid_i = 1'b1;
        rd_addr_i  = 8'h60;
        flush_i    = 1'b1;
        #1;
        chk("fl_rd_ready", 32'(rd_ready_o), 32'd1);
        chk("fl_ram_cen", 32'(ram_cen_o), 32'd1);
        chk("fl_ram_wen", 32'(ram_wen_o), 32'd0);
        chk("fl_ram_a", 32'(ram_a_o), 32'h60);
        tick();
        flush_i = 1'b0;
        #1;
        chk("fl_rd_data_valid", 32'(rd_data_valid_o), 32'd1);
        chk("fl_rd_data", 32'(rd_data_o), 32'h5);
        run_sweep(256, 50, "sweep_fl");
        #1;
        chk("fl_init_done", 32'(init_done_o), 32'd1);
        chk("fl_post_rd_ready", 32'(rd_ready_o), 32'd1);
        chk("fl_post_ram_a", 32'(ram_a_o), 32'h60);
        tick();
        rd_valid_i = 1'b0;
        #1;
        chk("fl_post_rd_valid", 32'(rd_data_valid_o), 32'd1);
        chk("fl_post_rd_data", 32'(rd_data_o), 32'd0);
        tick();
`endif

        // Reset in the middle of a read abandons the pending data.
        rd_valid_i = 1'b1;
        rd_addr_i  = 8'h12;
        #1;
        chk("rr_rd_ready", 32'(rd_ready_o), 32'd1);
        tick();
        rd_valid_i = 1'b0;
        rst = 1'b1;
        #1;
        chk("rr_rd_data_valid", 32'(rd_data_valid_o), 32'd0);
        chk("rr_ram_cen", 32'(ram_cen_o), 32'd0);
        chk("rr_init_done", 32'(init_done_o), 32'd0);
        tick();
        rst = 1'b0;

`ifdef TAG_RAM_CTRL_INIT_EN
        // Reset at sweep index 100 restarts the sweep from index 0.
        run_sweep(100, -1, "sweep_part");
        rst = 1'b1;
        #1;
        chk("rs_ram_cen", 32'(ram_cen_o), 32'd0);
        chk("rs_init_done", 32'(init_done_o), 32'd0);
        tick();
        rst = 1'b0;
        run_sweep(256, -1, "sweep_rst");
        #1;
        chk("rs_init_done_end", 32'(init_done_o), 32'd1);
        tick();
`else
        // Without the sweep: ready right away and flush_i has no effect.
        wr_valid_i = 1'b1;
        wr_addr_i  = 8'h12;
        wr_data_i  = 22'h3;
        flush_i    = 1'b1;
        #1;
        chk("nf_init_done", 32'(init_done_o), 32'd1);
        chk("nf_wr_ready", 32'(wr_ready_o), 32'd1);
        tick();
        wr_valid_i = 1'b0;
        flush_i    = 1'b0;
        rd_valid_i = 1'b1;
        rd_addr_i  = 8'h12;
        #1;
        chk("nf_init_done_after_flush", 32'(init_done_o), 32'd1);
        chk("nf_rd_ready", 32'(rd_ready_o), 32'd1);
        tick();
        rd_valid_i = 1'b0;
        #1;
        chk("nf_rd_data_valid", 32'(rd_data_valid_o), 32'd1);
        chk("nf_rd_data", 32'(rd_data_o), 32'h3);
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
